uart_xmtr_fifo: RTL and testbench
=================================

Name: uart_xmtr_fifo

Overview:
Parametrised successor to the single-word UART transmitter.
- Accepts words from the APB-side write path into an internal FIFO.
- Serialises each word as a UART frame: start bit, WD_SIZE data bits LSB first, optional parity, 1 or 2 stop bits.
- Baud rate is set at run time by a divisor input.
- Sits between the APB slave register block and the TXD pad.

Parameters:
WD_SIZE, 8, data bits per frame; legal range 5..9.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (default 16 words).
DIV_W, 16, width of the baud divisor input.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
bus_data_i  input  WD_SIZE  word to transmit.
load_xmt_i  input  1  push strobe; one word per cycle high.
baud_div_i  input  DIV_W  bit period = baud_div_i+1 clk cycles.
stop2_i  input  1  1 = two stop bits, 0 = one.
par_en_i  input  1  parity enable (see Optional Feature).
par_odd_i  input  1  1 = odd parity, 0 = even.
seri_data_o  output  1  serial TXD line; idle high.
busy_o  output  1  frame in progress.
full_o  output  1  FIFO full.
empty_o  output  1  FIFO empty.
level_o  output  FIFO_AW+1  words currently in FIFO.
ovf_o  output  1  one-cycle pulse: push dropped because FIFO was full.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs next cycle: seri_data_o=1, busy_o=0, full_o=0, empty_o=1, level_o=0, ovf_o=0.
  - FIFO pointers cleared, baud counter cleared, FSM to IDLE.
  - Reset mid-frame aborts the frame; the line returns high on the following cycle.
- FIFO push:
  - load_xmt_i=1 and full_o=0 writes bus_data_i; level_o increments next cycle.
  - load_xmt_i=1 and full_o=1 drops the word and pulses ovf_o next cycle.
  - full_o is evaluated before any same-cycle pop, so a push at full is always dropped.
  - Simultaneous push and pop when not full leaves level_o unchanged.
- Pointers wrap modulo 2**FIFO_AW. level_o ranges 0..2**FIFO_AW. full_o = (level_o == 2**FIFO_AW). empty_o = (level_o == 0).
- Configuration latch: baud_div_i, stop2_i, par_en_i and par_odd_i are latched at pop. Changes mid-frame take effect on the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: seri_data_o=1, busy_o=0. If empty_o=0, pop the head word into the shift register, latch config, clear the baud counter and go to START.
  - START: seri_data_o=0 for one bit period.
  - DATA: shift out WD_SIZE bits LSB first, one bit period each, using a bit counter 0..WD_SIZE-1.
  - PARITY: entered only if the latched parity enable is set. One bit period carrying the XOR of the data bits, inverted when par_odd is set.
  - STOP: seri_data_o=1 for 1 bit period, or 2 if stop2 is latched. Then go to IDLE, or straight to START if the FIFO is non-empty (the pop occurs in the last STOP cycle), giving back-to-back frames with no idle gap.
- Baud counter:
  - Counts 0..baud_div; the bit boundary is when the count equals baud_div, then it wraps to 0.
  - baud_div_i=0 gives one bit per clk.
- Latency: a word pushed at edge N into an empty FIFO with an idle FSM is popped at edge N+1. The start bit appears on seri_data_o from edge N+2.
- busy_o is 1 from the first START cycle through the last STOP cycle, registered with seri_data_o.
- Frame length in clocks = (baud_div+1) x (1 + WD_SIZE + P + S), where P = 0/1 parity and S = 1/2 stop bits.

Optional Feature:
Macro: UART_XMTR_PARITY_EN
- Defined: PARITY state and parity logic are present, and par_en_i/par_odd_i behave as above.
- Undefined: PARITY state is not synthesised, par_en_i/par_odd_i are ignored (ports are kept for a stable interface), and P = 0 always.

Test Plan:
1. Single word, 8N1: WD_SIZE=8, baud_div_i=3, push 8'd79 (0x4F) -> start bit at push+2 cycles. Line shows 0,1,1,1,1,0,0,1,0,1, each bit 4 clocks. busy_o high for 40 clocks, then seri_data_o=1, busy_o=0.
2. Back-to-back: push 0x55 then 0xAA on consecutive cycles, baud_div_i=0 -> level_o reaches 1 or 2. 20 contiguous bit clocks with no idle gap between frames; empty_o=1 after the second pop.
3. Overflow: FIFO_AW=2, baud_div_i=9, push 6 words on consecutive cycles -> first pop drains one. level_o peaks at 4 and full_o asserts. ovf_o pulses once for the dropped word; transmitted order matches the accepted words.
4. Parity (macro defined): push 0x4F with par_en_i=1, par_odd_i=0 -> parity bit 1. Repeat with par_odd_i=1 -> parity bit 0. Frame is 11 bit periods.
5. Two stop bits plus config latch: stop2_i=1 at pop, then toggle stop2_i=0 and baud_div_i mid-frame -> the current frame keeps 2 stop bits and the old period. The next frame uses the new settings.
6. Reset mid-frame: assert rst during DATA of 0x4F -> next cycle seri_data_o=1, busy_o=0, level_o=0, empty_o=1. No further frame until a new push.

Source files
------------

// File: rtl/uart_xmtr_fifo.sv
// uart_xmtr_fifo: FIFO-buffered UART transmitter.
// Words pushed from the register side are queued, then sent as
// start + WD_SIZE data bits (LSB first) + optional parity + 1/2 stop bits.
// Optional parity support is compiled in with the UART_XMTR_PARITY_EN macro.
module uart_xmtr_fifo #(
    parameter int WD_SIZE = 8,
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WD_SIZE-1:0] bus_data_i,
    input  logic               load_xmt_i,
    input  logic [DIV_W-1:0]   baud_div_i,
    input  logic               stop2_i,
    input  logic               par_en_i,
    input  logic               par_odd_i,
    output logic               seri_data_o,
    output logic               busy_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [FIFO_AW:0]   level_o,
    output logic               ovf_o
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int LVL_W = FIFO_AW + 1;
    localparam int BIT_W = $clog2(WD_SIZE);
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WD_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_XMTR_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_XMTR_PARITY_EN
    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic parity_bit(input logic [WD_SIZE-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction
`endif

    // FIFO storage and bookkeeping
    logic [WD_SIZE-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic               push, pop;

    // Transmit engine
    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WD_SIZE-1:0] sh_q, sh_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               stop2_q, stop2_d;
    logic               seri_q, seri_d;
    logic               busy_q, busy_d;
    logic               tick;
    logic               load_frame;
`ifdef UART_XMTR_PARITY_EN
    logic               par_en_q, par_en_d;
    logic               par_q, par_d;
`else
    logic               unused_par_cfg;
    assign unused_par_cfg = par_en_i ^ par_odd_i;
`endif

    assign full_o      = (level_q == DEPTH_L);
    assign empty_o     = (level_q == '0);
    assign level_o     = level_q;
    assign ovf_o       = ovf_q;
    assign seri_data_o = seri_q;
    assign busy_o      = busy_q;

    // A push is judged against the registered full flag, so a push at full is dropped even if a pop happens
    assign push = load_xmt_i & ~full_o;

    // FIFO pointer, level and overflow next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        ovf_d    = load_xmt_i & full_o;
    end

    // Frame sequencer: baud timing, bit counting, pop and config latch
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        div_d      = div_q;
        stop2_d    = stop2_q;
        pop        = 1'b0;
        load_frame = 1'b0;
`ifdef UART_XMTR_PARITY_EN
        par_en_d   = par_en_q;
        par_d      = par_q;
`endif
        tick = (cnt_q == div_q);
        if (state_q != S_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (!empty_o) load_frame = 1'b1;
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    sh_d = sh_q >> 1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_XMTR_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                        bit_d = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_XMTR_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
`endif
            S_STOP: begin
                // bit_q counts stop bits here; a waiting word starts with no idle gap
                if (tick) begin
                    if (stop2_q && (bit_q == '0)) begin
                        bit_d = BIT_W'(1);
                    end else if (!empty_o) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load_frame) begin
            pop     = 1'b1;
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
            sh_d    = mem_q[rd_ptr_q];
            div_d   = baud_div_i;
            stop2_d = stop2_i;
`ifdef UART_XMTR_PARITY_EN
            par_en_d = par_en_i;
            par_d    = parity_bit(mem_q[rd_ptr_q], par_odd_i);
`endif
        end
    end

    // Line level and busy flag, registered one cycle behind the sequencer state
    always_comb begin
        seri_d = 1'b1;
        busy_d = (state_q != S_IDLE);
        case (state_q)
            S_START:  seri_d = 1'b0;
            S_DATA:   seri_d = sh_q[0];
`ifdef UART_XMTR_PARITY_EN
            S_PARITY: seri_d = par_q;
`endif
            default:  seri_d = 1'b1;
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            seri_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            seri_q   <= seri_d;
            busy_q   <= busy_d;
        end
    end

    // Datapath registers: FIFO storage, shifter and latched frame config
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus_data_i;
        sh_q    <= sh_d;
        div_q   <= div_d;
        stop2_q <= stop2_d;
`ifdef UART_XMTR_PARITY_EN
        par_en_q <= par_en_d;
        par_q    <= par_d;
`endif
    end

endmodule

// File: tb/tb_uart_xmtr_fifo.sv
// tb_uart_xmtr_fifo: table-driven frames plus hand-written corner sequences.
// A line monitor pops expected frames from a scoreboard queue as start bits appear.
module tb_uart_xmtr_fifo;

    localparam int WD = 8;
    localparam int AW = 2;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [WD-1:0] bus_data_i;
    logic          load_xmt_i;
    logic [DW-1:0] baud_div_i;
    logic          stop2_i;
    logic          par_en_i;
    logic          par_odd_i;
    logic          seri_data_o;
    logic          busy_o;
    logic          full_o;
    logic          empty_o;
    logic [AW:0]   level_o;
    logic          ovf_o;

    always #5 clk = ~clk;

    uart_xmtr_fifo #(.WD_SIZE(WD), .FIFO_AW(AW), .DIV_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_data_i  (bus_data_i),
        .load_xmt_i  (load_xmt_i),
        .baud_div_i  (baud_div_i),
        .stop2_i     (stop2_i),
        .par_en_i    (par_en_i),
        .par_odd_i   (par_odd_i),
        .seri_data_o (seri_data_o),
        .busy_o      (busy_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .level_o     (level_o),
        .ovf_o       (ovf_o)
    );

    typedef struct {
        logic [11:0] bits;   // line bits in time order, bit 0 = start bit
        int          nbits;
        int          div;
    } frame_t;

    typedef struct {
        logic [7:0]  data;
        int          div;
        bit          stop2;
        bit          par_en;
        bit          par_odd;
        logic [11:0] exp_bits;
        int          exp_nbits;
    } vec_t;

    frame_t exp_q[$];
    vec_t   vecs[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     mon_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic frame_t mk_frame(input logic [11:0] bits, input int nbits, input int div);
        frame_t f;
        f.bits  = bits;
        f.nbits = nbits;
        f.div   = div;
        return f;
    endfunction

    // 8N1 frame: start 0, data LSB first, one stop bit
    function automatic frame_t frame_8n1(input logic [7:0] w, input int div);
        return mk_frame({3'b000, 1'b1, w, 1'b0}, 10, div);
    endfunction

    task automatic push_word(input logic [7:0] w);
        @(negedge clk);
        bus_data_i = w;
        load_xmt_i = 1'b1;
        @(negedge clk);
        load_xmt_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy_o) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, " drain in time"}, int'(t < 3000), 1);
    endtask

    // Line monitor: each start bit pops one expected frame and checks every bit period
    initial begin : line_monitor
        frame_t e;
        logic   bad_bit;
        logic   bad_busy;
        forever begin
            @(negedge clk);
            if (mon_en && seri_data_o == 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected start bit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < e.nbits; k++) begin
                        bad_bit  = 1'b0;
                        bad_busy = 1'b0;
                        for (int c = 0; c <= e.div; c++) begin
                            if (k != 0 || c != 0) @(negedge clk);
                            if (seri_data_o !== e.bits[k]) bad_bit = 1'b1;
                            if (busy_o !== 1'b1) bad_busy = 1'b1;
                        end
                        check($sformatf("line bit %0d", k),
                              int'(bad_bit ? ~e.bits[k] : e.bits[k]), int'(e.bits[k]));
                        check($sformatf("busy in bit %0d", k), int'(!bad_busy), 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        vec_t        v;
        int          lat;
        int          len;
        int          bad;
        logic [7:0]  ow [6];
        int          lvl_exp [6];
        int          ovf_exp [6];

        vecs.push_back('{data:8'h4F, div:3, stop2:1'b0, par_en:1'b0, par_odd:1'b0,
                         exp_bits:12'b00_1010011110, exp_nbits:10});
        vecs.push_back('{data:8'h00, div:0, stop2:1'b1, par_en:1'b0, par_odd:1'b0,
                         exp_bits:12'b0_11000000000, exp_nbits:11});
        vecs.push_back('{data:8'hFF, div:1, stop2:1'b0, par_en:1'b0, par_odd:1'b0,
                         exp_bits:12'b00_1111111110, exp_nbits:10});
        vecs.push_back('{data:8'h81, div:2, stop2:1'b1, par_en:1'b0, par_odd:1'b0,
                         exp_bits:12'b0_11100000010, exp_nbits:11});
`ifdef UART_XMTR_PARITY_EN
        vecs.push_back('{data:8'h4F, div:1, stop2:1'b0, par_en:1'b1, par_odd:1'b0,
                         exp_bits:12'b0_11010011110, exp_nbits:11});
        vecs.push_back('{data:8'h4F, div:1, stop2:1'b0, par_en:1'b1, par_odd:1'b1,
                         exp_bits:12'b0_10010011110, exp_nbits:11});
`endif

        // Reset state
        rst        = 1'b1;
        bus_data_i = '0;
        load_xmt_i = 1'b0;
        baud_div_i = '0;
        stop2_i    = 1'b0;
        par_en_i   = 1'b0;
        par_odd_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset seri", int'(seri_data_o), 1);
        check("reset busy", int'(busy_o), 0);
        check("reset full", int'(full_o), 0);
        check("reset empty", int'(empty_o), 1);
        check("reset level", int'(level_o), 0);
        check("reset ovf", int'(ovf_o), 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single frames from the vector table
        for (int i = 0; i < vecs.size(); i++) begin
            v          = vecs[i];
            baud_div_i = 16'(v.div);
            stop2_i    = v.stop2;
            par_en_i   = v.par_en;
            par_odd_i  = v.par_odd;
            exp_q.push_back(mk_frame(v.exp_bits, v.exp_nbits, v.div));
            push_word(v.data);
            check($sformatf("vec%0d level after push", i), int'(level_o), 1);
            lat = 0;
            while (!busy_o && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d start latency", i), lat, 2);
            len = 0;
            while (busy_o && len < 1000) begin
                len++;
                @(negedge clk);
            end
            check($sformatf("vec%0d busy length", i), len, v.exp_nbits * (v.div + 1));
            check($sformatf("vec%0d idle seri", i), int'(seri_data_o), 1);
            check($sformatf("vec%0d idle empty", i), int'(empty_o), 1);
            check($sformatf("vec%0d idle level", i), int'(level_o), 0);
            check($sformatf("vec%0d no ovf", i), int'(ovf_o), 0);
            check($sformatf("vec%0d frame consumed", i), exp_q.size(), 0);
        end

        // Back-to-back frames at one clock per bit
        baud_div_i = 16'd0;
        stop2_i    = 1'b0;
        par_en_i   = 1'b0;
        exp_q.push_back(mk_frame(12'b00_1010101010, 10, 0));
        exp_q.push_back(mk_frame(12'b00_1101010100, 10, 0));
        @(negedge clk);
        bus_data_i = 8'h55;
        load_xmt_i = 1'b1;
        @(negedge clk);
        check("b2b level first push", int'(level_o), 1);
        bus_data_i = 8'hAA;
        @(negedge clk);
        load_xmt_i = 1'b0;
        check("b2b level push with pop", int'(level_o), 1);
        lat = 0;
        while (!busy_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("b2b start latency", lat, 1);
        len = 0;
        while (busy_o && len < 1000) begin
            len++;
            @(negedge clk);
        end
        check("b2b contiguous busy", len, 20);
        check("b2b empty after", int'(empty_o), 1);
        check("b2b frames consumed", exp_q.size(), 0);

        // Overflow with a 4-deep FIFO
        ow      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        lvl_exp = '{1, 1, 2, 3, 4, 4};
        ovf_exp = '{0, 0, 0, 0, 0, 1};
        baud_div_i = 16'd9;
        for (int i = 0; i < 5; i++) exp_q.push_back(frame_8n1(ow[i], 9));
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus_data_i = ow[i];
            load_xmt_i = 1'b1;
            @(negedge clk);
            check($sformatf("ovf level %0d", i), int'(level_o), lvl_exp[i]);
            check($sformatf("ovf full %0d", i), int'(full_o), int'(lvl_exp[i] == 4));
            check($sformatf("ovf pulse %0d", i), int'(ovf_o), ovf_exp[i]);
        end
        load_xmt_i = 1'b0;
        @(negedge clk);
        check("ovf single pulse", int'(ovf_o), 0);
        check("ovf level held", int'(level_o), 4);
        wait_drain("ovf");
        check("ovf frames consumed", exp_q.size(), 0);
        check("ovf level drained", int'(level_o), 0);

        // Two stop bits latched at pop; config changed mid-frame applies to the next word
        baud_div_i = 16'd2;
        stop2_i    = 1'b1;
        exp_q.push_back(mk_frame(12'b0_11001111000, 11, 2));
        exp_q.push_back(mk_frame(12'b00_1110000110, 10, 5));
        push_word(8'h3C);
        @(negedge clk);
        baud_div_i = 16'd5;
        stop2_i    = 1'b0;
        bus_data_i = 8'hC3;
        load_xmt_i = 1'b1;
        @(negedge clk);
        load_xmt_i = 1'b0;
        len = 0;
        while (busy_o && len < 1000) begin
            len++;
            @(negedge clk);
        end
        check("cfg latch total busy", len, 33 + 60);
        check("cfg latch frames consumed", exp_q.size(), 0);

        // Reset in the middle of a frame with a word still queued
        mon_en     = 1'b0;
        baud_div_i = 16'd3;
        @(negedge clk);
        bus_data_i = 8'h4F;
        load_xmt_i = 1'b1;
        @(negedge clk);
        bus_data_i = 8'h12;
        @(negedge clk);
        load_xmt_i = 1'b0;
        repeat (10) @(negedge clk);
        check("busy before mid reset", int'(busy_o), 1);
        check("level before mid reset", int'(level_o), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset seri", int'(seri_data_o), 1);
        check("mid reset busy", int'(busy_o), 0);
        check("mid reset level", int'(level_o), 0);
        check("mid reset empty", int'(empty_o), 1);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (!seri_data_o || busy_o) bad++;
        end
        check("quiet after reset", bad, 0);

        // Recovery after reset
        mon_en = 1'b1;
        exp_q.push_back(frame_8n1(8'hA5, 3));
        push_word(8'hA5);
        wait_drain("recover");
        check("recover frames consumed", exp_q.size(), 0);
        check("recover idle seri", int'(seri_data_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
